// File: rtl/rr_grant_if.sv
// Request/grant bundle between the requester FSMs and the round-robin arbiter.
// The master side is the arbiter (drives grants); the slave side is the requester group.
interface rr_grant_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0] req;
  logic             release_grant;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             busy;
  logic             timeout;

  modport master (
    input  req,
    input  release_grant,
    output grant,
    output grant_id,
    output busy,
    output timeout
  );

  modport slave (
    output req,
    output release_grant,
    input  grant,
    input  grant_id,
    input  busy,
    input  timeout
  );
endinterface

// File: rtl/rr_grant_controller.sv
// Round-robin arbiter: one grant at a time, held until release, request drop or hold limit,
// followed by a one-cycle recovery gap. grant_id feeds the shared datapath's source mux.
module rr_grant_controller #(
  parameter int N_REQ    = 4,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic       clock,
  input  logic       reset,
  rr_grant_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  localparam logic [ID_W:0] N_REQ_W  = (ID_W + 1)'(N_REQ);
  localparam logic [7:0]    HOLD_LIM = 8'(MAX_HOLD);

  state_t           state;
  logic [N_REQ-1:0] grant_q;
  logic [ID_W-1:0]  grant_id_q;
  logic             busy_q;
  logic             timeout_q;
  logic [7:0]       hold_cnt;
  logic [ID_W-1:0]  rr_ptr;

  logic [N_REQ-1:0] req;
  logic             rel;
  logic             win_found;
  logic [ID_W-1:0]  win_id;
  logic             owner_req;
  logic             at_limit;
  logic             grant_end;
  logic [ID_W-1:0]  next_ptr;

  // Increment modulo N_REQ; also correct for non-power-of-two requester counts.
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
    logic [ID_W:0] s;
    s = {1'b0, v} + (ID_W + 1)'(1);
    if (s >= N_REQ_W) s = '0;
    return s[ID_W-1:0];
  endfunction

  // Scan downward so the last hit kept is the nearest asserted request at or above ptr.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [ID_W-1:0]  p);
    logic [ID_W:0]    k;
    logic [N_REQ-1:0] sh;
    logic [ID_W:0]    res;
    res = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = {1'b0, p} + (ID_W + 1)'(i);
      if (k >= N_REQ_W) k = k - N_REQ_W;
      sh = r >> k;
      if (sh[0]) res = {1'b1, k[ID_W-1:0]};
    end
    return res;
  endfunction

  assign req = bus.req;
  assign rel = bus.release_grant;

  always_comb begin
    {win_found, win_id} = rr_pick(req, rr_ptr);
    owner_req = |(req & grant_q);
    at_limit  = (hold_cnt == HOLD_LIM);
    grant_end = rel || !owner_req || at_limit;
    next_ptr  = wrap_inc(grant_id_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      hold_cnt   <= '0;
      rr_ptr     <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            state      <= GRANT;
            grant_q    <= N_REQ'(1) << win_id;
            grant_id_q <= win_id;
            busy_q     <= 1'b1;
            hold_cnt   <= 8'd1;
          end
        end
        GRANT: begin
          if (grant_end) begin
            state      <= RECOVER;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            hold_cnt   <= '0;
            rr_ptr     <= next_ptr;
            // Only a revocation forced purely by the hold limit is flagged.
            timeout_q  <= !rel && owner_req;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        RECOVER: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = busy_q;
  assign bus.timeout  = timeout_q;

  a_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(grant_q));
  a_busy:   assert property (@(posedge clock) disable iff (reset) busy_q == (|grant_q));
  a_id:     assert property (@(posedge clock) disable iff (reset)
                             (grant_q == '0) ? (grant_id_q == '0)
                                             : (grant_q == (N_REQ'(1) << grant_id_q)));

endmodule

// File: tb/tb_rr_grant_controller.sv
// Bench for rr_grant_controller: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural arbiter model (owner / cycles held / pointer / gap).
module tb_rr_grant_controller;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int MH = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  rr_grant_if #(.N_REQ(N), .ID_W(IW)) bus ();

  rr_grant_controller #(.N_REQ(N), .ID_W(IW), .MAX_HOLD(MH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: who owns the resource, for how long, where the search starts,
  // whether we're in the post-grant gap, and whether the last edge was a timeout.
  int m_owner = -1;
  int m_held  = 0;
  int m_ptr   = 0;
  int m_gap   = 0;
  int m_to    = 0;

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(logic rst_v, logic [N-1:0] r, logic rl);
    if (rst_v) begin
      m_owner = -1; m_held = 0; m_ptr = 0; m_gap = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (m_owner >= 0) begin
        if (rl || !r[m_owner] || m_held == MH) begin
          m_to    = (!rl && r[m_owner]) ? 1 : 0;
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_held  = 0;
          m_gap   = 1;
        end else begin
          m_held++;
        end
      end else if (m_gap != 0) begin
        m_gap = 0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (m_owner < 0 && r[(m_ptr + i) % N]) begin
            m_owner = (m_ptr + i) % N;
            m_held  = 1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_g;
    logic [31:0] idx;
    exp_g = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    check_val("grant",    32'(bus.grant), exp_g);
    check_val("grant_id", 32'(bus.grant_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check_val("busy",     32'(bus.busy), (m_owner >= 0) ? 32'd1 : 32'd0);
    check_val("timeout",  32'(bus.timeout), 32'(m_to));
    check_val("onehot0",  32'($onehot0(bus.grant)), 32'd1);
    check_val("busy_or",  32'(bus.busy), 32'(|bus.grant));
    idx = 32'd0;
    for (int i = 0; i < N; i++) if (bus.grant[i]) idx = 32'(i);
    check_val("id_idx",   32'(bus.grant_id), idx);
  endtask

  task automatic cycle(logic rst_v, logic [N-1:0] r, logic rl);
    reset             = rst_v;
    bus.req           = r;
    bus.release_grant = rl;
    model_step(rst_v, r, rl);
    @(posedge clock);
    #1;
    compare_all();
  endtask

  function automatic logic rel_at(int n);
    return (m_owner >= 0 && m_held == n);
  endfunction

  initial begin
    logic [N-1:0] rq;
    logic         rl, rs;
    reset = 1'b1;
    bus.req = '0;
    bus.release_grant = 1'b0;

    // Reset then a single request that is later dropped
    repeat (2) cycle(1'b1, 4'b0000, 1'b0);
    repeat (3) cycle(1'b0, 4'b0010, 1'b0);
    repeat (4) cycle(1'b0, 4'b0000, 1'b0);

    // Fairness: all request, each grantee releases after two cycles
    repeat (24) cycle(1'b0, 4'b1111, rel_at(2));
    repeat (3) cycle(1'b0, 4'b0000, 1'b0);

    // Hold limit with a lone persistent requester
    repeat (24) cycle(1'b0, 4'b0100, 1'b0);
    repeat (3) cycle(1'b0, 4'b0000, 1'b0);

    // Release coinciding with the hold limit
    repeat (24) cycle(1'b0, 4'b0100, rel_at(MH));
    repeat (3) cycle(1'b0, 4'b0000, 1'b0);

    // Wrap and skip: leave pointer at 3, then 0101, with req[3] rising mid-grant
    repeat (2) cycle(1'b0, 4'b0100, 1'b0);
    cycle(1'b0, 4'b0100, 1'b1);
    repeat (4) cycle(1'b0, 4'b0101, 1'b0);
    repeat (2) cycle(1'b0, 4'b1101, 1'b0);
    cycle(1'b0, 4'b1101, 1'b1);
    repeat (5) cycle(1'b0, 4'b0101, 1'b0);
    repeat (3) cycle(1'b0, 4'b0000, 1'b0);

    // Reset in the middle of a grant
    repeat (4) cycle(1'b0, 4'b1111, 1'b0);
    cycle(1'b1, 4'b1111, 1'b0);
    repeat (4) cycle(1'b0, 4'b1111, 1'b0);

    // Randomized traffic with sticky requests so hold limits are reached
    rq = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) rq = N'($urandom);
      rl = ($urandom_range(5) == 0);
      rs = ($urandom_range(149) == 0);
      cycle(rs, rq, rl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_grant_controller.md
Name: rr_grant_controller

Overview:
- Round-robin arbiter FSM that shares one resource among N_REQ requesters, such as the two-input Mealy controllers built in this lab series.
- Grants one requester at a time and holds the grant until that requester releases it or a hold limit expires.
- Inserts a one-cycle recovery gap between grants.
- Sits between the requester FSMs and the shared datapath; its grant_id drives the datapath's source-select mux.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of grant_id; must satisfy 2**ID_W >= N_REQ.
- MAX_HOLD, 8, maximum consecutive grant cycles before forced revocation (1..255).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N_REQ  request lines, level-sensitive, one per requester.
- release  input  1  pulse from the current grantee ending its grant; ignored when no grant is active.
- grant  output  N_REQ  one-hot grant vector, registered.
- grant_id  output  ID_W  index of the granted requester, registered; 0 when no grant.
- busy  output  1  high while in the GRANT state.
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Reset: synchronous. On a clock edge with reset=1, all of the following take effect on that edge:
  - state=IDLE; grant=0; grant_id=0; busy=0; timeout=0; hold_cnt=0; rr_ptr=0 (requester 0 has highest priority).
  - reset asserted during GRANT drops the grant at the same edge; no timeout pulse.
- States: IDLE, GRANT, RECOVER; 2-bit encoding.
- IDLE:
  - If any req bit is 1, choose the winner: the first asserted req searching upward from rr_ptr, wrapping N_REQ-1 -> 0.
  - Next edge: state=GRANT, grant=onehot(winner), grant_id=winner, busy=1, hold_cnt=1.
  - Latency is req to grant = 1 cycle.
  - If no req bit is 1, remain in IDLE.
- GRANT (grantee g):
  - End condition is any of: release=1; req[g]=0; hold_cnt==MAX_HOLD.
  - On end, next edge: state=RECOVER, grant=0, grant_id=0, busy=0, rr_ptr=(g+1) mod N_REQ.
  - timeout=1 for one cycle only when the hold limit is the sole cause, i.e. release=0 and req[g]=1.
  - Otherwise hold_cnt increments, saturating at MAX_HOLD.
  - Requests from other requesters never preempt the grant.
- RECOVER:
  - Lasts exactly one cycle with all outputs zero (timeout may still be high from the revocation edge).
  - Then goes to IDLE; arbitration uses the updated rr_ptr.
  - Minimum spacing between grants is therefore 2 idle cycles: grant low for RECOVER plus IDLE.
- Simultaneous events: release and hold-limit in the same cycle counts as a normal release (timeout=0).
- Arithmetic: rr_ptr wraps modulo N_REQ, including non-power-of-2 N_REQ. hold_cnt is 8 bits.
- Invariants, checked every cycle:
  - grant is always one-hot or zero.
  - grant_id equals the index of the set grant bit.
  - busy == |grant.
- Unused req bits above N_REQ do not exist; no X propagates from undriven inputs after reset.

Test Plan:
- Reset then single request: reset 2 cycles; req=0010 -> one cycle later grant=0010, grant_id=1, busy=1. Drop req -> next edge grant=0; RECOVER 1 cycle; IDLE.
- Round-robin fairness: req=1111 held, each grantee pulses release after 2 cycles -> grant order 0,1,2,3,0. Each grant lasts 2 cycles, with 2 non-granted cycles between grants.
- Hold limit: req=0100 held, release=0, MAX_HOLD=8 -> grant high exactly 8 cycles. timeout=1 for 1 cycle at revocation; rr_ptr=3. Next grant goes to 2 again since it is the only requester (after 2 gap cycles).
- Simultaneous release and limit: release pulsed in cycle 8 of a grant -> revocation with timeout=0.
- Wrap and skip: N_REQ=4, rr_ptr=3, req=0101 -> winner 0, then 2 after release. No preemption when req[3] rises mid-grant.
- Reset mid-grant: reset=1 during GRANT -> at that edge grant=0, busy=0, timeout=0, rr_ptr=0. With req=1111 after reset, first grant goes to requester 0.
